// File: rtl/cart_loader.sv
// Cartridge image loader: captures a download into a 2^ADDR_W byte RAM,
// derives a power-of-two mirroring mask, and serves mirrored CPU reads.
module cart_loader #(
  parameter logic [7:0] CART_INDEX = 8'd1,
  parameter int          ADDR_W     = 13
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  input  logic [15:0]       cpu_addr,
  input  logic              cpu_rd,
  output logic [7:0]        cpu_dout,
  output logic              cart_loaded,
  output logic [ADDR_W:0]   cart_size,
  output logic [ADDR_W-1:0] cart_mask,
  output logic [7:0]        cart_sum,
  output logic              overflow
);

  localparam int              DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] ONE   = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {IDLE, LOAD, MASK, READY} state_t;

  state_t state, state_nxt;

  logic [7:0]        ram [DEPTH];
  logic              dl_prev;
  logic              wait_q;
  logic              vld_p0;
  logic [ADDR_W-1:0] wr_addr_p0;
  logic [7:0]        wr_data_p0;

  logic              idx_match;
  logic              start;
  logic              strobe;
  logic              in_range;
  logic              accept;
  logic [ADDR_W:0]   byte_end;
  logic [ADDR_W:0]   size_m1;
  logic              mask_done;
  logic [ADDR_W-1:0] rd_addr;
  logic              unused_cpu_hi;

  // Shifting in a one saturates at all-ones on its own.
  function automatic logic [ADDR_W-1:0] grow_mask(input logic [ADDR_W-1:0] m);
    return {m[ADDR_W-2:0], 1'b1};
  endfunction

  // Only a fresh rising edge of the window starts a load, so a window left
  // high across reset cannot restart one.
  assign idx_match = (ioctl_index == CART_INDEX);
  assign start     = ioctl_download & ~dl_prev & idx_match &
                     ((state == IDLE) | (state == READY));
  assign strobe    = (state == LOAD) & ioctl_download & idx_match & ioctl_wr & ~wait_q;
  assign in_range  = (ioctl_addr[24:ADDR_W] == '0);
  assign accept    = strobe & in_range;
  assign byte_end  = {1'b0, ioctl_addr[ADDR_W-1:0]} + ONE;
  assign size_m1   = cart_size - ONE;
  assign mask_done = ({1'b0, cart_mask} >= size_m1);
  assign rd_addr   = cpu_addr[ADDR_W-1:0] & cart_mask;
  assign unused_cpu_hi = &{1'b0, cpu_addr[15:ADDR_W]};

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (!ioctl_download) state_nxt = MASK;
      MASK: begin
        if (cart_size == '0)  state_nxt = IDLE;
        else if (mask_done)   state_nxt = READY;
      end
      READY:   if (start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ioctl_wait  = wait_q | (state == MASK);
    cart_loaded = (state == READY);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_prev   <= 1'b1;
      wait_q    <= 1'b0;
      vld_p0    <= 1'b0;
      cart_size <= '0;
      cart_mask <= '0;
      cart_sum  <= '0;
      overflow  <= 1'b0;
    end else begin
      dl_prev <= ioctl_download;
      wait_q  <= strobe;
      vld_p0  <= accept;
      if (start) begin
        cart_size <= '0;
        cart_mask <= '0;
        cart_sum  <= '0;
        overflow  <= 1'b0;
      end else begin
        if (accept) begin
          cart_sum <= cart_sum + ioctl_dout;
          if (byte_end > cart_size) cart_size <= byte_end;
        end
        if (strobe && !in_range) overflow <= 1'b1;
        if (state == MASK && cart_size != '0 && !mask_done)
          cart_mask <= grow_mask(cart_mask);
      end
    end
  end

  // p0: strobed byte registered, written to RAM on the following edge
  always_ff @(posedge clk_sys) begin
    wr_addr_p0 <= ioctl_addr[ADDR_W-1:0];
    wr_data_p0 <= ioctl_dout;
  end

  always_ff @(posedge clk_sys) begin
    if (vld_p0) ram[wr_addr_p0] <= wr_data_p0;
  end

  always_ff @(posedge clk_sys) begin
    if (reset)       cpu_dout <= 8'hFF;
    else if (cpu_rd) cpu_dout <= (state == READY) ? ram[rd_addr] : 8'hFF;
  end

endmodule

// File: doc/cart_loader.md
CART_LOADER -- requirements
Module: cart_loader

Interface
REQ-001 SHALL have parameter CART_INDEX, default 8'd1, the ioctl_index value that selects a cartridge download.
REQ-002 SHALL have parameter ADDR_W, default 13, the log2 of cartridge storage depth (8 KiB).
REQ-003 clk_sys  in  1  system clock; all logic SHALL be on its rising edge (one clock only).
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ioctl_download  in  1  download window active.
REQ-006 ioctl_index  in  8  download target index.
REQ-007 ioctl_wr  in  1  one-cycle strobe, byte valid.
REQ-008 ioctl_addr  in  25  byte address of the strobed byte.
REQ-009 ioctl_dout  in  8  strobed byte.
REQ-010 ioctl_wait  out  1  back-pressure to the writer.
REQ-011 cpu_addr  in  16  CPU cartridge-space address.
REQ-012 cpu_rd  in  1  CPU read request.
REQ-013 cpu_dout  out  8  read data.
REQ-014 cart_loaded  out  1  image valid and readable.
REQ-015 cart_size  out  ADDR_W+1  bytes stored.
REQ-016 cart_mask  out  ADDR_W  mirroring mask.
REQ-017 cart_sum  out  8  modulo-256 sum of stored bytes.
REQ-018 overflow  out  1  image exceeded 2^ADDR_W bytes.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD, MASK and READY.
REQ-020 IDLE->LOAD SHALL occur when ioctl_download=1 and ioctl_index==CART_INDEX; on entry, size, sum and overflow SHALL clear and cart_loaded SHALL drop.
REQ-021 Downloads with any other index SHALL be ignored in every state.
REQ-022 In LOAD, each ioctl_wr with ioctl_addr<2^ADDR_W SHALL write ioctl_dout to RAM[ioctl_addr[ADDR_W-1:0]] one cycle later, via a registered write pipeline.
REQ-023 For the same byte, sum += byte (wrap mod 256) and size = max(size, ioctl_addr+1).
REQ-024 A strobe with ioctl_addr>=2^ADDR_W SHALL set overflow, SHALL NOT write RAM, and SHALL NOT change size or sum.
REQ-025 ioctl_wait SHALL be 1 in the cycle after each accepted strobe and throughout MASK, and 0 otherwise.
REQ-026 A strobe arriving while ioctl_wait=1 is a protocol error and SHALL be dropped.
REQ-027 LOAD->MASK SHALL occur on the cycle ioctl_download falls; the pending pipelined write SHALL still complete.
REQ-028 MASK SHALL compute cart_mask = (smallest power of two >= size) - 1, saturating to all-ones, iteratively, one bit per cycle.
REQ-029 MASK SHALL take at most ADDR_W+1 cycles and then go to READY.
REQ-030 A size of 0 SHALL yield mask 0, go to IDLE, and leave cart_loaded=0.
REQ-031 READY SHALL assert cart_loaded; a new matching download SHALL return the FSM to LOAD (REQ-020).
REQ-032 CPU read latency SHALL be 1 cycle: cpu_dout = RAM[cpu_addr & cart_mask] registered when cpu_rd=1 in READY.
REQ-033 cpu_dout SHALL hold its value when cpu_rd=0.
REQ-034 In any state other than READY, a cpu_rd SHALL return 8'hFF.
REQ-035 Only cpu_addr[ADDR_W-1:0] SHALL be used for reads, giving mirroring across the whole 16-bit space.
REQ-036 The RAM SHALL be single-port; loader writes and CPU reads never coincide because reads are gated to READY.

Reset
REQ-037 reset SHALL force IDLE, ioctl_wait=0, cart_loaded=0, cart_size=0, cart_mask=0, cart_sum=0, overflow=0, cpu_dout=8'hFF, and cancel any pending write.
REQ-038 reset asserted mid-LOAD or mid-MASK SHALL abort the operation; RAM contents are undefined and cart_loaded stays 0.
REQ-039 After reset with ioctl_download still high, the loader SHALL NOT re-enter LOAD until a fresh rising edge of the download window with a matching index.

Verification
REQ-040 Scenario: load 4096 bytes of value (addr&0xFF) at index 1 -> cart_size=4096, cart_mask=0x0FFF, cart_sum=0x00, cart_loaded=1, and reading cpu_addr=0x1005 returns 0x05.
REQ-041 Scenario: load 3000 bytes -> cart_mask=0x0FFF; cpu_addr=0x0C00 reads back the byte at 0x0C00 (undefined area, not checked), while cpu_addr=0x1001 returns byte 0x001.
REQ-042 Scenario: load 8200 bytes -> overflow=1, cart_size=8192, cart_mask=0x1FFF, and byte 8192 is not written.
REQ-043 Scenario: download with index 2 -> no state change, and cart_loaded keeps its prior value.
REQ-044 Scenario: strobes on back-to-back cycles -> the second is dropped and ioctl_wait=1 in that cycle; strobes spaced 2 cycles apart are all accepted.
REQ-045 Scenario: reset pulsed mid-load after 100 bytes -> all outputs at reset values, and a cpu_rd returns 0xFF.
